// File: rtl/btn_pkg.sv
// Shared constants for the button debouncer: FSM state encoding
// and the counter-width helper.
package btn_pkg;

  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;

  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, qualify FSM, level/pulse regs.
// Ports: clk, rst_n, btn_i (polarity-corrected), level_o/rise_o/fall_o/long_o.
// Macro LONG_PRESS_EN adds the hold counter that drives long_o.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LONG_CYC     = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > 32'd16777216) begin : g_bad_deb
    $error("btn_debounce_ch: DEBOUNCE_CYC out of range");
  end
  if (LONG_CYC < 2) begin : g_bad_long
    $error("btn_debounce_ch: LONG_CYC must be at least 2");
  end

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          btn_s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // sync_q[1] is the second stage, i.e. the synchronised pin
  always_comb begin
    sync_d = {sync_q[0], btn_i};
  end

  assign btn_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef LONG_PRESS_EN
  // One extra code point above LONG_CYC-1 marks "already fired",
  // so the counter parks there and never re-triggers.
  localparam int unsigned HW = cnt_width(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYC);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Counts from the accepted press; a release glitch keeps counting.
  always_comb begin
    hold_d = '0;
    long_d = 1'b0;
    if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (hold_q == HOLD_LAST) begin
        long_d = 1'b1;
        hold_d = HOLD_SAT;
      end else if (hold_q == HOLD_SAT) begin
        hold_d = hold_q;
      end else begin
        hold_d = hold_q + HW'(1);
      end
      if (state_d == IDLE) begin
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_BTN raw pins into clean levels and one-cycle events.
// Ports: clk, rst_n, btn_i -> btn_level/btn_rise/btn_fall/btn_long. Macro: LONG_PRESS_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC   = 1000000,
  parameter bit          BTN_ACTIVE_LOW = 1'b0,
  parameter int unsigned LONG_CYC       = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic [NUM_BTN-1:0] btn_long
);

  logic [NUM_BTN-1:0] btn_pol;

  // Everything downstream treats 1 as "pressed".
  assign btn_pol = BTN_ACTIVE_LOW ? ~btn_i : btn_i;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_pol[i]),
      .level_o (btn_level[i]),
      .rise_o  (btn_rise[i]),
      .fall_o  (btn_fall[i]),
      .long_o  (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (DEBOUNCE_CYC=8, LONG_CYC=20).
// Table vectors, timed corner sequences and random stimulus vs a run-length model.
module tb_btn_debounce;

  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 20;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_i = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic [N-1:0] btn_long;

  always #5 clk = ~clk;

  btn_debounce #(
    .NUM_BTN        (N),
    .DEBOUNCE_CYC   (D),
    .BTN_ACTIVE_LOW (1'b0),
    .LONG_CYC       (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     (btn_i),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_long  (btn_long)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: a level flips once the synchronised pin has
  // disagreed with it for D+1 consecutive edges (one edge to leave
  // the stable state, D edges of qualification).
  int           run [N];
  int           since [N];
  logic [N-1:0] m_lvl, m_rise, m_fall, m_long;
  logic [N-1:0] p1, p2;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      run[c] = 0;
      since[c] = 0;
    end
    m_lvl = '0;
    m_rise = '0;
    m_fall = '0;
    m_long = '0;
    p1 = '0;
    p2 = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] pin);
    logic was;
    m_rise = '0;
    m_fall = '0;
    m_long = '0;
    for (int c = 0; c < N; c++) begin
      was = m_lvl[c];
      if (p2[c] != m_lvl[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          run[c] = 0;
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
      if (was) begin
        since[c]++;
        if (since[c] == L && LONG_ON) m_long[c] = 1'b1;
      end
      if (m_rise[c]) since[c] = 0;
    end
    p2 = p1;
    p1 = pin;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(btn_i);
    #1;
    check("model", {btn_level, btn_rise, btn_fall, btn_long},
          {m_lvl, m_rise, m_fall, m_long});
  endtask

  // Applies pins and reports the step index of the first rise/fall pulse.
  task automatic timed_edge(input string nm, input logic [N-1:0] pins,
                            input bit is_rise, input logic [N-1:0] exp_vec);
    int found;
    logic [N-1:0] vec;
    found = 0;
    vec = '0;
    btn_i = pins;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (found == 0 && (is_rise ? btn_rise : btn_fall) != '0) begin
        found = i;
        vec = is_rise ? btn_rise : btn_fall;
      end
    end
    check({nm, "_cycle"}, found, 11);
    check({nm, "_vec"}, vec, exp_vec);
  endtask

  typedef struct {
    logic [N-1:0] btn;
    int           cycles;
    logic [N-1:0] exp_level;
    logic [N-1:0] exp_rise_or;
    logic [N-1:0] exp_fall_or;
    int           exp_npulse;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [N-1:0] r_or, f_or;
    int np, lcnt, lidx, ridx;
    int tmr [N];

    tbl.push_back('{4'h0, 12, 4'h0, 4'h0, 4'hF, 4});
    tbl.push_back('{4'h1, 12, 4'h1, 4'h1, 4'h0, 1});
    tbl.push_back('{4'h0, 12, 4'h0, 4'h0, 4'h1, 1});
    tbl.push_back('{4'h2, 5,  4'h0, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h0, 3,  4'h0, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h2, 6,  4'h0, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h0, 12, 4'h0, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h4, 12, 4'h4, 4'h4, 4'h0, 1});
    tbl.push_back('{4'h0, 4,  4'h4, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h4, 12, 4'h4, 4'h0, 4'h0, 0});
    tbl.push_back('{4'h0, 12, 4'h0, 4'h0, 4'h4, 1});
    tbl.push_back('{4'h9, 12, 4'h9, 4'h9, 4'h0, 2});
    tbl.push_back('{4'h0, 12, 4'h0, 4'h0, 4'h9, 2});

    model_reset();

    // Reset with all pins held, then a full qualification after release
    btn_i = 4'hF;
    for (int i = 0; i < 3; i++) step();
    check("reset_outs", {btn_level, btn_rise, btn_fall, btn_long}, 16'h0);
    rst_n = 1'b1;
    timed_edge("reset_rise", 4'hF, 1'b1, 4'hF);
    check("reset_level", btn_level, 4'hF);

    foreach (tbl[t]) begin
      r_or = '0;
      f_or = '0;
      np = 0;
      btn_i = tbl[t].btn;
      for (int i = 0; i < tbl[t].cycles; i++) begin
        step();
        r_or |= btn_rise;
        f_or |= btn_fall;
        np += $countones(btn_rise) + $countones(btn_fall);
      end
      check($sformatf("tbl%0d_level", t), btn_level, tbl[t].exp_level);
      check($sformatf("tbl%0d_rise", t), r_or, tbl[t].exp_rise_or);
      check($sformatf("tbl%0d_fall", t), f_or, tbl[t].exp_fall_or);
      check($sformatf("tbl%0d_npulse", t), np, tbl[t].exp_npulse);
    end

    // Exact latency of press/release and simultaneous presses
    timed_edge("ch0_press", 4'h1, 1'b1, 4'h1);
    timed_edge("ch0_release", 4'h0, 1'b0, 4'h1);
    check("ch0_level_low", btn_level, 4'h0);
    timed_edge("sim_press", 4'h9, 1'b1, 4'h9);
    timed_edge("sim_release", 4'h0, 1'b0, 4'h9);

    // Reset in the middle of qualification
    btn_i = 4'h1;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_outs", {btn_level, btn_rise, btn_fall, btn_long}, 16'h0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    timed_edge("midrst_rise", 4'h1, 1'b1, 4'h1);
    timed_edge("midrst_release", 4'h0, 1'b0, 4'h1);

    // Long press on channel 0
    btn_i = 4'h1;
    lcnt = 0;
    lidx = 0;
    ridx = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (btn_rise[0] && ridx == 0) ridx = i;
      if (btn_long != '0) begin
        lcnt++;
        if (lidx == 0) lidx = i;
      end
    end
    check("long_rise_cycle", ridx, 11);
    if (LONG_ON) begin
      check("long_cycle", lidx, ridx + L);
      check("long_count", lcnt, 1);
    end else begin
      check("long_count", lcnt, 0);
    end
    btn_i = 4'h0;
    for (int i = 0; i < 14; i++) step();

    // Random per-channel pin activity against the model
    for (int c = 0; c < N; c++) tmr[c] = $urandom_range(1, 14);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        tmr[c]--;
        if (tmr[c] <= 0) begin
          btn_i[c] = ~btn_i[c];
          tmr[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45)
                                                : $urandom_range(1, 14);
        end
      end
      if (cyc == 2000) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst", {btn_level, btn_rise, btn_fall, btn_long}, 16'h0);
        step();
        rst_n = 1'b1;
      end
      step();
      check("rnd_excl", btn_rise & btn_fall, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
